arcade_input_mapper: RTL and testbench

Parametrised control-input front end for arcade cores. It merges PS/2 keyboard events and HPS joystick words into per-player control vectors, applies a selectable screen-rotation remap and optional autofire, and generates timed coin pulses with a small request queue. It sits between `hps_io` and the game core, replacing ad-hoc key decoding in each `emu` top.

---
 rtl/arcade_input_mapper.sv | 190 +++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 and joystick merge, rotation remap, autofire and queued coin pulses
// One registered control byte per player; bit 7 of each byte is that player's coin pulse.
module arcade_input_mapper #(
   parameter int          PLAYERS       = 2,
   parameter logic [15:0] COIN_PULSE    = 16'd2000,
   parameter logic [15:0] COIN_GAP      = 16'd2000,
   parameter logic [19:0] AF_DIV        = 20'd400000,
   parameter bit          COIN_ON_START = 1'b1
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic [64:0]          ps2_key,
   input  logic [15:0]          joy0,
   input  logic [15:0]          joy1,
   input  logic [1:0]           rot,
   input  logic [PLAYERS-1:0]   autofire,
   output logic [8*PLAYERS-1:0] ctrl
);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

   logic        toggle_q;
   logic        armed_q;
   logic        key_event;
   logic        key_release;
   logic        key_ext;
   logic [8:0]  key_id;
   logic [7:0]  hit1;
   logic [7:0]  hit2;
   logic [7:0]  keys1_q;
   logic [7:0]  keys2_q;
   logic [19:0] af_cnt_q;
   logic        af_phase_q;
   logic [PLAYERS-1:0][7:0] raw;
   logic        unused_bits;

   assign unused_bits = ^{joy0[15:8], joy1[15:8]};

   assign key_release = (ps2_key[15:8] == 8'hF0);
   assign key_ext     = key_release ? (ps2_key[23:16] == 8'hE0) : (ps2_key[15:8] == 8'hE0);
   assign key_id      = {key_ext, ps2_key[7:0]};
   // Multi-byte sequences such as PAUSE/PRNSCR carry extra bytes and are dropped.
   assign key_event   = armed_q && (ps2_key[64] != toggle_q) && (ps2_key[63:24] == 40'd0);

   always_comb begin
      hit1 = 8'h00;
      hit2 = 8'h00;
      case (key_id)
         9'h075, 9'h175: hit1[3] = 1'b1;
         9'h072, 9'h172: hit1[2] = 1'b1;
         9'h06B, 9'h16B: hit1[1] = 1'b1;
         9'h074, 9'h174: hit1[0] = 1'b1;
         9'h014:         hit1[4] = 1'b1;
         9'h029:         hit1[5] = 1'b1;
         9'h005:         hit1[6] = 1'b1;
         9'h02E:         hit1[7] = 1'b1;
         9'h02D:         hit2[3] = 1'b1;
         9'h02B:         hit2[2] = 1'b1;
         9'h023:         hit2[1] = 1'b1;
         9'h034:         hit2[0] = 1'b1;
         9'h01C:         hit2[4] = 1'b1;
         9'h01B:         hit2[5] = 1'b1;
         9'h006:         hit2[6] = 1'b1;
         9'h036:         hit2[7] = 1'b1;
         default: ;
      endcase
   end

   // The first cycle out of reset only captures the toggle so a stale event is not replayed.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q <= 1'b0;
         armed_q  <= 1'b0;
         keys1_q  <= 8'h00;
         keys2_q  <= 8'h00;
      end else begin
         toggle_q <= ps2_key[64];
         armed_q  <= 1'b1;
         if (key_event) begin
            if (key_release) begin
               keys1_q <= keys1_q & ~hit1;
               keys2_q <= keys2_q & ~hit2;
            end else begin
               keys1_q <= keys1_q | hit1;
               keys2_q <= keys2_q | hit2;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt_q   <= 20'd0;
         af_phase_q <= 1'b0;
      end else if (af_cnt_q == AF_DIV - 20'd1) begin
         af_cnt_q   <= 20'd0;
         af_phase_q <= ~af_phase_q;
      end else begin
         af_cnt_q <= af_cnt_q + 20'd1;
      end
   end

   generate
      if (PLAYERS == 1) begin : g_one
         assign raw[0] = keys1_q | keys2_q | joy0[7:0] | joy1[7:0];
      end else begin : g_two
         assign raw[0] = keys1_q | joy0[7:0];
         assign raw[1] = keys2_q | joy1[7:0];
      end
   endgenerate

   generate
      for (genvar p = 0; p < PLAYERS; p++) begin : g_player
         logic [6:0]  rotated;
         logic [6:0]  pad_q;
         logic [1:0]  cs_q;
         logic [1:0]  cs_qq;
         logic        req;
         logic        inc;
         logic        deq;
         logic [1:0]  pend_q;
         coin_state_t state_q;
         coin_state_t state_d;
         logic [15:0] cnt_q;
         logic [15:0] cnt_d;

         // Direction bits: [3]=U [2]=D [1]=L [0]=R.
         always_comb begin
            rotated = raw[p][6:0];
            case (rot)
               2'd1:    rotated[3:0] = {raw[p][1], raw[p][0], raw[p][2], raw[p][3]};
               2'd2:    rotated[3:0] = {raw[p][0], raw[p][1], raw[p][3], raw[p][2]};
               2'd3:    rotated[3:0] = {raw[p][2], raw[p][3], raw[p][0], raw[p][1]};
               default: ;
            endcase
            if (autofire[p]) rotated[4] = raw[p][4] & af_phase_q;
         end

         // cs_q holds {coin, start} as seen by the output register, cs_qq one cycle older.
         assign req = (cs_q[1] & ~cs_qq[1]) | (COIN_ON_START & cs_q[0] & ~cs_qq[0]);
         assign inc = req && (pend_q != 2'd3);
         assign deq = (state_q == IDLE) && (pend_q != 2'd0);

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
               IDLE: if (deq) begin
                  state_d = PULSE;
                  cnt_d   = COIN_PULSE - 16'd1;
               end
               PULSE: if (cnt_q == 16'd0) begin
                  state_d = GAP;
                  cnt_d   = COIN_GAP - 16'd1;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
               GAP: if (cnt_q == 16'd0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
               default: state_d = IDLE;
            endcase
         end

         always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
               pad_q   <= 7'd0;
               cs_q    <= 2'b00;
               cs_qq   <= 2'b00;
               pend_q  <= 2'd0;
               state_q <= IDLE;
               cnt_q   <= 16'd0;
            end else begin
               pad_q   <= rotated;
               cs_q    <= {raw[p][7], raw[p][6]};
               cs_qq   <= cs_q;
               state_q <= state_d;
               cnt_q   <= cnt_d;
               if (inc && !deq)      pend_q <= pend_q + 2'd1;
               else if (!inc && deq) pend_q <= pend_q - 2'd1;
            end
         end

         assign ctrl[8*p +: 8] = {state_q == PULSE, pad_q};
      end
   endgenerate

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - randomized bench against a behavioural model of arcade_input_mapper
module tb_arcade_input_mapper;
   localparam int P_LEN = 3;
   localparam int G_LEN = 2;
   localparam int AF    = 4;

   logic        clk_sys  = 1'b0;
   logic        reset_n  = 1'b0;
   logic [64:0] ps2_key  = '0;
   logic [15:0] joy0     = '0;
   logic [15:0] joy1     = '0;
   logic [1:0]  rot      = '0;
   logic [1:0]  autofire = '0;
   logic [15:0] ctrl;

   arcade_input_mapper #(
      .PLAYERS(2), .COIN_PULSE(16'd3), .COIN_GAP(16'd2), .AF_DIV(20'd4), .COIN_ON_START(1'b1)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy0(joy0), .joy1(joy1),
      .rot(rot), .autofire(autofire), .ctrl(ctrl)
   );

   always #5 clk_sys = ~clk_sys;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Keymap as a table: {ext, code} -> player*8 + bit.
   logic [8:0] km_id [20] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h174,
                              9'h014, 9'h029, 9'h005, 9'h02E, 9'h02D, 9'h02B, 9'h023, 9'h034,
                              9'h01C, 9'h01B, 9'h006, 9'h036};
   int km_pb [20] = '{3, 3, 2, 2, 1, 1, 0, 0, 4, 5, 6, 7, 11, 10, 9, 8, 12, 13, 14, 15};
   // rot_src[mode][out] = source direction index, with 0=R 1=L 2=D 3=U.
   int rot_src [4][4] = '{'{0, 1, 2, 3}, '{3, 2, 0, 1}, '{2, 3, 1, 0}, '{1, 0, 3, 2}};

   logic [15:0] m_keys;
   logic        m_tog;
   logic        m_armed;
   int          cyc;
   int          m_pend [2];
   int          m_busy [2];
   int          m_start [2];
   logic [1:0]  m_cs [2];
   logic [1:0]  m_cs_prev [2];

   logic        mon_prev [2];
   bit          mon_seen [2];
   int          mon_hi [2];
   int          mon_lo [2];
   int          mon_rises [2] = '{0, 0};

   task automatic model_reset();
      m_keys  = '0;
      m_tog   = 1'b0;
      m_armed = 1'b0;
      cyc     = 0;
      for (int p = 0; p < 2; p++) begin
         m_pend[p]    = 0;
         m_busy[p]    = 0;
         m_start[p]   = -100;
         m_cs[p]      = 2'b00;
         m_cs_prev[p] = 2'b00;
         mon_prev[p]  = 1'b0;
         mon_seen[p]  = 1'b0;
         mon_hi[p]    = 0;
         mon_lo[p]    = 0;
      end
   endtask

   // Expected ctrl after the edge just taken; pulses are tracked as start cycle and busy-until cycle.
   task automatic model_edge(output logic [15:0] exp);
      logic [7:0] raw [2];
      logic [7:0] v;
      logic       phase;
      logic       req;
      logic       inc;
      logic       dec;
      logic       rel;
      logic [8:0] id;
      cyc++;
      raw[0] = m_keys[7:0]  | joy0[7:0];
      raw[1] = m_keys[15:8] | joy1[7:0];
      phase  = (((cyc - 1) / AF) % 2) == 1;
      for (int p = 0; p < 2; p++) begin
         v = '0;
         for (int b = 0; b < 4; b++) v[b] = raw[p][rot_src[rot][b]];
         v[4] = raw[p][4] & (!autofire[p] || phase);
         v[5] = raw[p][5];
         v[6] = raw[p][6];
         req  = (m_cs[p][1] & ~m_cs_prev[p][1]) | (m_cs[p][0] & ~m_cs_prev[p][0]);
         dec  = (cyc - 1 >= m_busy[p]) && (m_pend[p] > 0);
         inc  = req && (m_pend[p] < 3);
         if (dec) begin
            m_start[p] = cyc;
            m_busy[p]  = cyc + P_LEN + G_LEN;
         end
         m_pend[p]    = m_pend[p] + int'(inc) - int'(dec);
         m_cs_prev[p] = m_cs[p];
         m_cs[p]      = {raw[p][7], raw[p][6]};
         v[7] = (cyc >= m_start[p]) && (cyc < m_start[p] + P_LEN);
         exp[8*p +: 8] = v;
      end
      if (m_armed && (ps2_key[64] != m_tog) && (ps2_key[63:24] == 40'd0)) begin
         rel = (ps2_key[15:8] == 8'hF0);
         id  = {rel ? (ps2_key[23:16] == 8'hE0) : (ps2_key[15:8] == 8'hE0), ps2_key[7:0]};
         for (int i = 0; i < 20; i++) if (km_id[i] == id) m_keys[km_pb[i]] = !rel;
      end
      m_armed = 1'b1;
      m_tog   = ps2_key[64];
   endtask

   task automatic step();
      logic [15:0] exp;
      logic        c;
      @(posedge clk_sys);
      #1;
      model_edge(exp);
      check_eq("ctrl", ctrl, exp);
      for (int p = 0; p < 2; p++) begin
         c = ctrl[8*p+7];
         if (c && !mon_prev[p]) begin
            mon_rises[p]++;
            if (mon_seen[p]) check_eq("coin_gap_min", mon_lo[p] >= G_LEN, 1);
            mon_hi[p] = 1;
         end else if (c) begin
            mon_hi[p]++;
         end else if (mon_prev[p]) begin
            check_eq("coin_high_len", mon_hi[p], P_LEN);
            mon_lo[p]   = 1;
            mon_seen[p] = 1'b1;
         end else begin
            mon_lo[p]++;
         end
         mon_prev[p] = c;
      end
   endtask

   task automatic kb(input bit rel, input bit ext, input logic [7:0] code);
      logic [7:0] b23;
      logic [7:0] b15;
      b23 = (rel && ext) ? 8'hE0 : 8'h00;
      b15 = rel ? 8'hF0 : (ext ? 8'hE0 : 8'h00);
      ps2_key[63:0] = {40'd0, b23, b15, code};
      ps2_key[64]   = ~ps2_key[64];
   endtask

   int         toggles;
   int         ones;
   int         base;
   int         r;
   int         idx;
   logic [8:0] kid;
   logic       prev_bit;

   initial begin
      model_reset();
      reset_n = 1'b0;
      ps2_key = {1'b1, 40'd0, 24'h000014};
      repeat (3) @(posedge clk_sys);
      #1;
      check_eq("reset_ctrl", ctrl, 16'h0000);
      reset_n = 1'b1;

      repeat (4) step();
      check_eq("first_sample_no_fire", ctrl[4], 1'b0);
      kb(0, 0, 8'h14);
      step();
      step();
      check_eq("fire_after_toggle", ctrl[4], 1'b1);
      kb(1, 0, 8'h14);
      step();
      step();

      kb(0, 1, 8'h75);
      step();
      check_eq("up_t1", ctrl[3], 1'b0);
      step();
      check_eq("up_t2", ctrl[3], 1'b1);
      kb(1, 1, 8'h75);
      step();
      check_eq("up_rel_t1", ctrl[3], 1'b1);
      step();
      check_eq("up_rel_t2", ctrl[3], 1'b0);
      rot = 2'd1;
      kb(0, 1, 8'h75);
      step();
      step();
      check_eq("up_rot1_r", ctrl[0], 1'b1);
      check_eq("up_rot1_u", ctrl[3], 1'b0);
      kb(1, 1, 8'h75);
      step();
      step();
      rot = 2'd0;
      step();

      ps2_key = {~ps2_key[64], 40'hE11477E1F0, 24'h000014};
      repeat (3) step();
      check_eq("ignored_event", ctrl[4], 1'b0);

      joy1[4] = 1'b1;
      autofire[1] = 1'b1;
      step();
      prev_bit = ctrl[12];
      toggles = 0;
      repeat (16) begin
         step();
         if (ctrl[12] != prev_bit) toggles++;
         prev_bit = ctrl[12];
      end
      check_eq("af_toggles", toggles, 4);
      autofire[1] = 1'b0;
      step();
      ones = 0;
      repeat (16) begin
         step();
         ones += int'(ctrl[12]);
      end
      check_eq("af_off_steady", ones, 16);
      joy1 = '0;
      repeat (10) step();

      base = mon_rises[0];
      repeat (4) begin
         kb(0, 0, 8'h05);
         step();
         kb(1, 0, 8'h05);
         step();
      end
      repeat (40) step();
      check_eq("coin_f1_pulses", mon_rises[0] - base, 4);

      base = mon_rises[0];
      for (int i = 0; i < 6; i++) begin
         joy0[7:6] = (i % 2 == 0) ? 2'b10 : 2'b01;
         step();
      end
      joy0 = '0;
      repeat (40) step();
      check_eq("coin_six_req_pulses", mon_rises[0] - base, 4);

      joy0[7] = 1'b1;
      step();
      step();
      check_eq("coin_lat_t2", ctrl[7], 1'b0);
      step();
      check_eq("coin_lat_t3", ctrl[7], 1'b1);
      joy0[7] = 1'b0;
      step();
      check_eq("coin_before_reset", ctrl[7], 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("reset_mid_pulse", ctrl, 16'h0000);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      model_reset();
      reset_n = 1'b1;
      repeat (10) step();

      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         if (r < 30) begin
            idx = $urandom_range(0, 19);
            kid = km_id[idx];
            kb(1'($urandom_range(0, 1)), kid[8], kid[7:0]);
         end else if (r < 35) begin
            ps2_key[63:0] = {40'd0, 24'($urandom)};
            ps2_key[64]   = ~ps2_key[64];
         end else if (r < 37) begin
            ps2_key[63:24] = 40'($urandom_range(1, 255)) << 8;
            ps2_key[64]    = ~ps2_key[64];
         end
         if ($urandom_range(0, 5) == 0) joy0 = 16'($urandom);
         if ($urandom_range(0, 5) == 0) joy1 = 16'($urandom);
         if ($urandom_range(0, 40) == 0) rot = 2'($urandom);
         if ($urandom_range(0, 40) == 0) autofire = 2'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
